mc_control: RTL and testbench

Multi-cycle main control FSM for the MIPS datapath. Sequences every instruction through fetch/decode/execute/memory/writeback states and drives all datapath enables and mux selects, including `ALU_SrcB[2:0]` and `Ex_top` consumed by the operand-B extension/select logic. Sits between the instruction register (opcode/funct fields) and the datapath. It also handles memory wait states via `mem_ready`.

---
 rtl/mc_control.sv | 213 +++++++++++++++++++++
 tb/tb_mc_control.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PC_we,
  output logic       IorD,
  output logic       Mem_read,
  output logic       Mem_write,
  output logic       IR_write,
  output logic       Reg_write,
  output logic       Mem_to_reg,
  output logic       Reg_dst,
  output logic       ALU_SrcA,
  output logic [2:0] ALU_SrcB,
  output logic       Ex_top,
  output logic [2:0] ALU_op,
  output logic [1:0] PC_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LOAD_WB  = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  localparam logic [2:0] SRCB_RT     = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH = 3'd3;
  localparam logic [2:0] SRCB_UPPER  = 3'd4;

  state_t state_q;
  state_t state_d;
  state_t cur;

  function automatic logic r_funct_ok(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Unsupported encodings fall back to FETCH; DECODE flags that as illegal.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW, OP_SW:                      return S_MEM_ADDR;
      OP_RTYPE:                          return r_funct_ok(fn) ? S_R_EX : S_FETCH;
      OP_BEQ:                            return S_BRANCH;
      OP_J:                              return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  return S_I_EX;
      default:                           return S_FETCH;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    PC_we      = 1'b0;
    IorD       = 1'b0;
    Mem_read   = 1'b0;
    Mem_write  = 1'b0;
    IR_write   = 1'b0;
    Reg_write  = 1'b0;
    Mem_to_reg = 1'b0;
    Reg_dst    = 1'b0;
    ALU_SrcA   = 1'b0;
    ALU_SrcB   = SRCB_RT;
    Ex_top     = 1'b1;
    ALU_op     = ALU_ADD;
    PC_source  = 2'd0;
    illegal_op = 1'b0;
    state_d    = state_q;
    // Under reset the outputs decode as FETCH so the datapath sees a sane idle.
    cur        = reset ? S_FETCH : state_q;

    case (cur)
      S_FETCH: begin
        Mem_read = 1'b1;
        ALU_SrcB = SRCB_FOUR;
        IR_write = mem_ready;
        PC_we    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALU_SrcB   = SRCB_IMM_SH;
        state_d    = decode_next(opcode, funct);
        illegal_op = (state_d == S_FETCH);
      end
      S_MEM_ADDR: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = SRCB_IMM;
        state_d  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        Mem_read = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        Reg_write  = 1'b1;
        Mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        Mem_write = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EX: begin
        ALU_SrcA = 1'b1;
        ALU_op   = r_alu_op(funct);
        state_d  = S_R_WB;
      end
      S_R_WB: begin
        Reg_write = 1'b1;
        Reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SrcA  = 1'b1;
        ALU_op    = ALU_SUB;
        PC_source = 2'd1;
        PC_we     = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PC_source = 2'd2;
        PC_we     = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EX, S_I_WB: begin
        // ALU operand selection stays put across writeback so ALUOut is stable.
        if (cur == S_I_EX) begin
          ALU_SrcA = 1'b1;
          state_d  = S_I_WB;
        end else begin
          Reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        case (opcode)
          OP_ADDI: begin ALU_SrcB = SRCB_IMM;   ALU_op = ALU_ADD; end
          OP_ANDI: begin ALU_SrcB = SRCB_IMM;   ALU_op = ALU_AND; if (cur == S_I_EX) Ex_top = 1'b0; end
          OP_ORI:  begin ALU_SrcB = SRCB_IMM;   ALU_op = ALU_OR;  if (cur == S_I_EX) Ex_top = 1'b0; end
          OP_LUI:  begin ALU_SrcB = SRCB_UPPER; ALU_op = ALU_PASS; end
          default: ;
        endcase
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      PC_we      = 1'b0;
      IR_write   = 1'b0;
      Reg_write  = 1'b0;
      Mem_write  = 1'b0;
      Mem_read   = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed table, hand sequences around reset, and random
// instruction streams checked cycle by cycle against a trace-level model.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PC_we, IorD, Mem_read, Mem_write, IR_write, Reg_write;
  logic       Mem_to_reg, Reg_dst, ALU_SrcA, Ex_top, illegal_op;
  logic [2:0] ALU_SrcB, ALU_op;
  logic [1:0] PC_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PC_we(PC_we), .IorD(IorD), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .IR_write(IR_write), .Reg_write(Reg_write),
    .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst), .ALU_SrcA(ALU_SrcA),
    .ALU_SrcB(ALU_SrcB), .Ex_top(Ex_top), .ALU_op(ALU_op), .PC_source(PC_source),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we, iord, mem_read, mem_write, ir_write, reg_write;
    logic       mem_to_reg, reg_dst, src_a;
    logic [2:0] src_b;
    logic       ex_top;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic mr;
    logic z;
    obs_t o;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         mw;
    int         lat;
  } vec_t;

  step_t q[$];

  function automatic obs_t sample();
    obs_t g;
    g.st = state; g.pc_we = PC_we; g.iord = IorD; g.mem_read = Mem_read;
    g.mem_write = Mem_write; g.ir_write = IR_write; g.reg_write = Reg_write;
    g.mem_to_reg = Mem_to_reg; g.reg_dst = Reg_dst; g.src_a = ALU_SrcA;
    g.src_b = ALU_SrcB; g.ex_top = Ex_top; g.alu_op = ALU_op;
    g.pc_source = PC_source; g.illegal = illegal_op;
    return g;
  endfunction

  function automatic obs_t idle(input logic [3:0] s);
    obs_t o = '0;
    o.st = s;
    o.ex_top = 1'b1;
    return o;
  endfunction

  function automatic int r_op(input logic [5:0] fn);
    case (fn)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2a: return 4;
      default: return -1;
    endcase
  endfunction

  // 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 j, 6 immediate ALU
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return 1;
      6'h2b: return 2;
      6'h00: return (r_op(fn) >= 0) ? 3 : 0;
      6'h04: return 4;
      6'h02: return 5;
      6'h08, 6'h0c, 6'h0d, 6'h0f: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic z, input obs_t o);
    step_t s;
    s.mr = mr; s.z = z; s.o = o;
    q.push_back(s);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    obs_t o;
    int   c;
    logic [2:0] sb, alu;
    logic ex;
    c = classify(op, fn);
    o = idle(4'd0); o.mem_read = 1'b1; o.src_b = 3'd1;
    for (int i = 0; i < fw; i++) push(1'b0, rbit(), o);
    o.ir_write = 1'b1; o.pc_we = 1'b1;
    push(1'b1, rbit(), o);
    o = idle(4'd1); o.src_b = 3'd3; o.illegal = (c == 0);
    push(rbit(), rbit(), o);
    case (c)
      1, 2: begin
        o = idle(4'd2); o.src_a = 1'b1; o.src_b = 3'd2;
        push(rbit(), rbit(), o);
        o = idle((c == 1) ? 4'd3 : 4'd5); o.iord = 1'b1;
        if (c == 1) o.mem_read = 1'b1; else o.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, rbit(), o);
        push(1'b1, rbit(), o);
        if (c == 1) begin
          o = idle(4'd4); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          push(rbit(), rbit(), o);
        end
      end
      3: begin
        o = idle(4'd6); o.src_a = 1'b1; o.src_b = 3'd0; o.alu_op = 3'(r_op(fn));
        push(rbit(), rbit(), o);
        o = idle(4'd7); o.reg_write = 1'b1; o.reg_dst = 1'b1;
        push(rbit(), rbit(), o);
      end
      4: begin
        o = idle(4'd8); o.src_a = 1'b1; o.alu_op = 3'd1; o.pc_source = 2'd1; o.pc_we = z;
        push(rbit(), z, o);
      end
      5: begin
        o = idle(4'd9); o.pc_source = 2'd2; o.pc_we = 1'b1;
        push(rbit(), rbit(), o);
      end
      6: begin
        case (op)
          6'h08:   begin sb = 3'd2; ex = 1'b1; alu = 3'd0; end
          6'h0c:   begin sb = 3'd2; ex = 1'b0; alu = 3'd2; end
          6'h0d:   begin sb = 3'd2; ex = 1'b0; alu = 3'd3; end
          default: begin sb = 3'd4; ex = 1'b1; alu = 3'd5; end
        endcase
        o = idle(4'd10); o.src_a = 1'b1; o.src_b = sb; o.ex_top = ex; o.alu_op = alu;
        push(rbit(), rbit(), o);
        o = idle(4'd11); o.reg_write = 1'b1; o.src_b = sb; o.alu_op = alu;
        push(rbit(), rbit(), o);
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, output int lat);
    obs_t g;
    q.delete();
    build(op, fn, z, fw, mw);
    lat = fw + 1;
    foreach (q[i]) begin
      @(negedge clk);
      reset = 1'b0; opcode = op; funct = fn;
      mem_ready = q[i].mr; zero = q[i].z;
      #1;
      g = sample();
      n_checks++;
      if (g !== q[i].o) begin
        n_fails++;
        $display("FAIL trace op=%h fn=%h step %0d: got state %0d outputs %h, expected state %0d outputs %h",
                 op, fn, i, g.st, g, q[i].o.st, q[i].o);
      end
      if (g.st != 4'd0) lat++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[15];
    logic [5:0] ops[9];
    logic [5:0] fns[5];
    int lat;
    logic [5:0] op, fn;

    tbl = '{
      '{6'h00, 6'h20, 1'b0, 0, 4}, '{6'h00, 6'h22, 1'b0, 0, 4},
      '{6'h00, 6'h2a, 1'b0, 0, 4}, '{6'h23, 6'h00, 1'b0, 0, 5},
      '{6'h23, 6'h11, 1'b0, 2, 7}, '{6'h2b, 6'h00, 1'b0, 0, 4},
      '{6'h2b, 6'h00, 1'b0, 1, 5}, '{6'h04, 6'h00, 1'b1, 0, 3},
      '{6'h04, 6'h00, 1'b0, 0, 3}, '{6'h02, 6'h00, 1'b0, 0, 3},
      '{6'h0c, 6'h00, 1'b0, 0, 4}, '{6'h0f, 6'h00, 1'b0, 0, 4},
      '{6'h08, 6'h00, 1'b0, 0, 4}, '{6'h3f, 6'h00, 1'b0, 0, 2},
      '{6'h00, 6'h21, 1'b0, 0, 2}
    };
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_enables", 32'({PC_we, IR_write, Reg_write, Mem_write, Mem_read, illegal_op}), 32'd0);
    chk("reset_srcb", 32'(ALU_SrcB), 32'd1);

    // First fetch after release, carrying a jump.
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; opcode = 6'h02; #1;
    chk("release_ir_pc_we", 32'({IR_write, PC_we}), 32'h3);
    chk("release_srcb", 32'(ALU_SrcB), 32'd1);
    @(negedge clk); #1;
    chk("j_decode_state", 32'(state), 32'd1);
    @(negedge clk); #1;
    chk("j_jump_state", 32'(state), 32'd9);
    chk("j_jump_ctl", 32'({PC_we, PC_source}), 32'h6);

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, 0, tbl[i].mw, lat);
      chk($sformatf("latency_vec%0d", i), 32'(lat), 32'(tbl[i].lat));
    end

    for (int n = 0; n < 150; n++) begin
      int k = $urandom_range(0, 9);
      op = (k == 9) ? 6'($urandom) : ops[k];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), lat);
    end

    // Reset during a stalled store abandons it.
    @(negedge clk); opcode = 6'h2b; mem_ready = 1'b1; #1;
    chk("sw_fetch_state", 32'(state), 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("sw_addr_state", 32'(state), 32'd2);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("sw_wr_ctl", 32'({state, Mem_write}), 32'hb);
    @(negedge clk); reset = 1'b1; #1;
    chk("sw_reset_mem_write", 32'(Mem_write), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("sw_reset_state", 32'(state), 32'd0);
    chk("sw_reset_no_write", 32'({Mem_write, Mem_read}), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
